// File: rtl/banked_ram.sv
// NUM_BANKS independent single-port RAMs. Each bank has a registered write-first read port.
// A shared clear engine zero-fills all banks after reset or on clear_req; ready is low while it runs.
module banked_ram #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int NUM_BANKS     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BANKS*ADDRESS_WIDTH-1:0] address,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]    data_write,
  input  logic [NUM_BANKS-1:0]               WR_signal,
  input  logic                               clear_req,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]    data_read,
  output logic                               ready,
  output logic                               busy_error
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                     busy_error_q, busy_error_d;
  logic                     clearing;

  assign clearing   = (state_q == ST_CLEAR);
  assign ready      = (state_q == ST_READY);
  assign busy_error = busy_error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clear_addr_q <= '0;
      busy_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      busy_error_q <= busy_error_d;
    end
  end

  // The terminal sweep address is all-ones, so clear_addr needs no extra bit.
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    busy_error_d = busy_error_q;
    case (state_q)
      ST_CLEAR: begin
        if (|WR_signal) busy_error_d = 1'b1;
        if (clear_addr_q == {ADDRESS_WIDTH{1'b1}}) begin
          state_d      = ST_READY;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clear_req) state_d = ST_CLEAR;
      end
      default: begin
        state_d      = ST_CLEAR;
        clear_addr_d = '0;
      end
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    rd_q;
    logic [ADDRESS_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0]    wdata_b;

    assign addr_b  = address[b*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_b = data_write[b*DATA_WIDTH +: DATA_WIDTH];

    // Memory array carries no reset; the sweep is what defines its contents.
    always_ff @(posedge clk) begin
      if (clearing) begin
        mem_q[clear_addr_q] <= '0;
      end else if (WR_signal[b]) begin
        mem_q[addr_b] <= wdata_b;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else if (clearing) begin
        rd_q <= '0;
      end else if (WR_signal[b]) begin
        rd_q <= wdata_b;
      end else begin
        rd_q <= mem_q[addr_b];
      end
    end

    assign data_read[b*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_banked_ram.sv
// Bench for banked_ram: directed vector table, multi-cycle clear/reset sequences,
// and random traffic checked against an array-based reference model.
module tb_banked_ram;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB*AW-1:0]  address = '0;
  logic [NB*DW-1:0]  data_write = '0;
  logic [NB-1:0]     WR_signal = '0;
  logic              clear_req = 1'b0;
  logic [NB*DW-1:0]  data_read;
  logic              ready;
  logic              busy_error;

  int checks = 0;
  int failures = 0;

  banked_ram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .data_write (data_write),
    .WR_signal  (WR_signal),
    .clear_req  (clear_req),
    .data_read  (data_read),
    .ready      (ready),
    .busy_error (busy_error)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays plus a count of clear edges still owed.
  logic [DW-1:0] m_mem [NB][DEPTH];
  logic [DW-1:0] m_rd  [NB];
  int            m_clear_left;
  logic          m_berr;

  task automatic chk(input string name, input logic [NB*DW-1:0] act, input logic [NB*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clear_left = DEPTH;
    m_berr       = 1'b0;
    for (int b = 0; b < NB; b++) m_rd[b] = '0;
  endtask

  task automatic model_edge();
    if (m_clear_left > 0) begin
      for (int b = 0; b < NB; b++) begin
        m_mem[b][DEPTH - m_clear_left] = '0;
        m_rd[b] = '0;
      end
      if (WR_signal != 0) m_berr = 1'b1;
      m_clear_left--;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (WR_signal[b]) begin
          m_mem[b][address[b*AW +: AW]] = data_write[b*DW +: DW];
          m_rd[b] = data_write[b*DW +: DW];
        end else begin
          m_rd[b] = m_mem[b][address[b*AW +: AW]];
        end
      end
      if (clear_req) m_clear_left = DEPTH;
    end
  endtask

  task automatic compare_model();
    logic [NB*DW-1:0] exp_rd;
    for (int b = 0; b < NB; b++) exp_rd[b*DW +: DW] = m_rd[b];
    chk("model_data_read", data_read, exp_rd);
    chk("model_ready", {255'd0, ready}, {255'd0, (m_clear_left == 0)});
    chk("model_busy_error", {255'd0, busy_error}, {255'd0, m_berr});
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input logic [NB-1:0] w, input logic [NB*AW-1:0] a,
                      input logic [NB*DW-1:0] d, input logic c);
    WR_signal  = w;
    address    = a;
    data_write = d;
    clear_req  = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
    clear_req = 1'b0;
    WR_signal = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_data_read", data_read, '0);
    chk("reset_ready", {255'd0, ready}, '0);
    chk("reset_busy_error", {255'd0, busy_error}, '0);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    do begin
      step('0, '0, '0, 1'b0);
      n++;
    end while (ready !== 1'b1 && n < 100);
  endtask

  typedef struct {
    logic [NB-1:0]    wr;
    logic [NB*AW-1:0] addr;
    logic [NB*DW-1:0] wdata;
    logic [NB*DW-1:0] exp_rd;
  } vec_t;

  localparam logic [DW-1:0] W0  = 64'h1110a716aa948111;
  localparam logic [DW-1:0] W1  = 64'h2220a716aa9485d9;
  localparam logic [DW-1:0] W2  = 64'h3330a716aa9485d9;
  localparam logic [DW-1:0] W3  = 64'h4440a716aa9485d9;
  localparam logic [DW-1:0] N0  = 64'h5550a716aa948111;
  localparam logic [DW-1:0] N2  = 64'h1230a716aa9485d9;
  localparam logic [DW-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] ONE = 64'h1;
  localparam logic [DW-1:0] Z   = 64'h0;

  vec_t vecs [9];

  initial begin
    int n;
    logic [NB*AW-1:0] ra;
    logic [NB*DW-1:0] rd_data;

    for (int b = 0; b < NB; b++)
      for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;

    // Address bus nibbles are {bank3, bank2, bank1, bank0}.
    vecs[0] = '{4'hF,    16'h4321, {W3, W2, W1, W0}, {W3, W2, W1, W0}};
    vecs[1] = '{4'h0,    16'h4321, '0,               {W3, W2, W1, W0}};
    vecs[2] = '{4'h0,    16'h4325, '0,               {W3, W2, W1, Z}};
    vecs[3] = '{4'b0101, 16'h4321, {Z, N2, Z, N0},   {W3, N2, W1, N0}};
    vecs[4] = '{4'h0,    16'h4321, '0,               {W3, N2, W1, N0}};
    vecs[5] = '{4'b1000, 16'hF000, {TOP, Z, Z, Z},   {TOP, Z, Z, Z}};
    vecs[6] = '{4'b1000, 16'h0000, {ONE, Z, Z, Z},   {ONE, Z, Z, Z}};
    vecs[7] = '{4'h0,    16'hF000, '0,               {TOP, Z, Z, Z}};
    vecs[8] = '{4'h0,    16'h0000, '0,               {ONE, Z, Z, Z}};

    // Power-up sweep
    do_reset();
    wait_ready(0, n);
    chk("first_sweep_edges", 256'(n), 256'd16);

    for (int i = 0; i < 9; i++) begin
      step(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0);
      chk($sformatf("vec%0d_data_read", i), data_read, vecs[i].exp_rd);
    end

    // clear_req with a write attempted during the sweep
    step('0, 16'h0000, '0, 1'b1);
    chk("clear_req_ready_low", {255'd0, ready}, '0);
    step(4'b0001, 16'h0001, {Z, Z, Z, 64'hdeadbeef}, 1'b0);
    wait_ready(1, n);
    chk("clear_req_sweep_edges", 256'(n), 256'd16);
    chk("busy_error_sticky", {255'd0, busy_error}, 256'd1);
    step('0, 16'h4321, '0, 1'b0);
    chk("cleared_words", data_read, '0);
    step('0, 16'hF000, '0, 1'b0);
    chk("cleared_top", data_read, '0);
    chk("busy_error_still", {255'd0, busy_error}, 256'd1);

    // Reset at clear edge 7 restarts the sweep
    step('0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step('0, '0, '0, 1'b0);
    do_reset();
    wait_ready(0, n);
    chk("restart_sweep_edges", 256'(n), 256'd16);
    chk("busy_error_cleared", {255'd0, busy_error}, '0);

    // Random traffic, addresses folded to 0..3 per bank to revisit written words
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom) & 16'h3333;
      for (int k = 0; k < NB * 2; k++) rd_data[k*32 +: 32] = $urandom;
      step(4'($urandom_range(0, 15)), ra, rd_data, ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised multi-bank single-port RAM for the ODE solver datapath. It generalises the fixed four-port RAM to NUM_BANKS independent banks of identical geometry. Each bank has a registered, write-first read port. A built-in clear engine zero-fills every bank after reset or on request, and signals readiness through `ready`, so solver memories start from a known state without testbench preloading.

## Interface
- DATA_WIDTH, 64, word width of every bank
- ADDRESS_WIDTH, 12, address bits per bank; DEPTH = 2**ADDRESS_WIDTH words per bank
- NUM_BANKS, 4, number of independent banks (1..16)

Ports (bank b occupies slice [b*W +: W] of each flattened bus, where W is the field width):
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- address  input  NUM_BANKS*ADDRESS_WIDTH  per-bank word address
- data_write  input  NUM_BANKS*DATA_WIDTH  per-bank write data
- WR_signal  input  NUM_BANKS  per-bank write enable; 1 = write, 0 = read
- clear_req  input  1  one-cycle pulse requesting a full zero-fill while ready
- data_read  output  NUM_BANKS*DATA_WIDTH  per-bank registered read data
- ready  output  1  1 = banks accept accesses; 0 = clear in progress
- busy_error  output  1  sticky; set if any WR_signal bit is high while ready = 0

## Operation
- States are CLEAR and READY. rst forces CLEAR with clear_addr = 0.
- CLEAR:
  - Each edge writes 0 to mem_b[clear_addr] in all banks in parallel, then increments clear_addr.
  - On the edge where clear_addr = DEPTH-1, the state moves to READY and clear_addr returns to 0.
  - User writes are ignored; data_read is held at 0.
  - If any WR_signal bit is 1 on an edge, busy_error is set to 1.
  - clear_req is ignored.
- READY: each edge, independently per bank b:
  - If WR_signal[b] = 1: mem_b[address_b] <= data_write_b, and data_read_b <= data_write_b (write-first).
  - Otherwise: data_read_b <= mem_b[address_b].
- clear_req in READY: on that edge the state moves to CLEAR and ready falls. The same-edge user access is still performed, and the clear then overwrites it.
- Banks never interact. Each bank's address is used unchanged as its word index; there is no cross-bank addressing.
- busy_error is cleared only by rst.

## Timing
- Reset values (asynchronous on rst rising):
  - data_read = 0, ready = 0, busy_error = 0
  - state = CLEAR, clear_addr = 0
  - Memory contents are not reset by rst; they are cleared by the CLEAR sweep.
- Clear duration is exactly DEPTH rising edges after rst deasserts, or after the clear_req edge.
- ready rises after the DEPTH-th clear edge; the first user access is accepted on the following edge.
- Read latency is 1 cycle: address is sampled at edge n, data is valid after edge n until edge n+1.
- Write takes effect at the sampling edge. A read of the same address on the next edge returns the new data.
- Simultaneous write and read on the same bank means the bank's one address is in write mode. data_read shows the written word (write-first).
- Different banks may write and read in the same cycle with no interaction.
- rst asserted mid-clear restarts the sweep from address 0 after release. rst asserted in READY aborts the current access, and contents are then zeroed by the new sweep.
- clear_addr is ADDRESS_WIDTH bits wide; the terminal test is clear_addr = DEPTH-1, so no extra bit is needed.

## Test plan
Bench uses ADDRESS_WIDTH = 4 (DEPTH = 16), NUM_BANKS = 4, DATA_WIDTH = 64.
- Reset, then release; count edges until ready = 1 -> ready = 0 for exactly 16 edges, then 1; data_read = 0 throughout; busy_error = 0.
- After ready, write bank0[1] = 64'h1110a716aa948111, bank1[2] = 64'h2220a716aa9485d9, bank2[3] = 64'h3330a716aa9485d9, bank3[4] = 64'h4440a716aa9485d9, then read all four -> each data_read matches one cycle after its read edge. Unwritten bank0[5] reads 0.
- Same cycle: write bank0 = 64'h5550a716aa948111 and bank2 = 64'h1230a716aa9485d9 while reading bank1 and bank3 -> bank0/bank2 data_read show the new words immediately (write-first); bank1/bank3 return prior contents 64'h2220..., 64'h4440....
- Pulse clear_req with WR_signal = 4'b0001 during the sweep -> ready low for 16 edges; busy_error = 1 and remains 1 afterwards. The write is ignored, and all previously written locations read 0 after ready.
- Assert rst at clear edge 7 of a sweep, then release -> the sweep restarts, and ready rises 16 edges after release, not 9.
- Write bank3[15] = 64'hFFFF_FFFF_FFFF_FFFF and bank3[0] = 64'h1, read both -> top-address word intact, no aliasing of address 15 onto 0.
